// File: rtl/ctrl_route_sched.sv
// rtl/ctrl_route_sched.sv - control-token scheduler for the ctrl mux/demux fabric (optional macro: CTRL_ROUTE_SCHED_STRICT_PRIO_EN selects fixed priority)
module ctrl_route_sched #(
    parameter int S_COUNT          = 2,
    parameter int D_COUNT          = 2,
    parameter int SELECTOR_WIDTH   = $clog2(S_COUNT),
    parameter int DISPATCHER_WIDTH = $clog2(D_COUNT),
    parameter int MAX_INFLIGHT     = 4,
    parameter int CNT_WIDTH        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [S_COUNT*DISPATCHER_WIDTH-1:0]   s_desc_tdata,
    input  logic [S_COUNT-1:0]                    s_desc_tvalid,
    output logic [S_COUNT-1:0]                    s_desc_tready,
    output logic [SELECTOR_WIDTH-1:0]             m_selector_tdata,
    output logic                                  m_selector_tvalid,
    input  logic                                  m_selector_tready,
    output logic [DISPATCHER_WIDTH-1:0]           m_dispatcher_tdata,
    output logic                                  m_dispatcher_tvalid,
    input  logic                                  m_dispatcher_tready,
    input  logic                                  s_done_tvalid,
    output logic [CNT_WIDTH-1:0]                  inflight_count,
    output logic [1:0]                            err_flags
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);

    state_t                        r_state;
    state_t                        w_state_next;

    logic [SELECTOR_WIDTH-1:0]     r_sel;
    logic [DISPATCHER_WIDTH-1:0]   r_disp;
    logic                          r_sel_vld;
    logic                          r_disp_vld;
    logic [CNT_WIDTH-1:0]          r_count;
    logic [1:0]                    r_err;

    logic                          w_sel_vld_next;
    logic                          w_disp_vld_next;
    logic                          w_found;
    logic [SELECTOR_WIDTH-1:0]     w_winner;
    logic                          w_lo_found;
    logic [SELECTOR_WIDTH-1:0]     w_lo_idx;
    logic [DISPATCHER_WIDTH-1:0]   w_dest;
    logic                          w_dest_ok;
    logic                          w_accept;
    logic                          w_issue;
    logic                          w_bad;
    logic                          w_dec;

`ifndef CTRL_ROUTE_SCHED_STRICT_PRIO_EN
    // Round-robin pointer: index of the most recently accepted source.
    logic [SELECTOR_WIDTH-1:0]     r_ptr;
    logic                          w_hi_found;
    logic [SELECTOR_WIDTH-1:0]     w_hi_idx;
`endif

    // Scan the valid vector; the descending loop leaves the lowest matching index.
    always_comb begin
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
`ifndef CTRL_ROUTE_SCHED_STRICT_PRIO_EN
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
`endif
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_desc_tvalid[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = SELECTOR_WIDTH'(i);
`ifndef CTRL_ROUTE_SCHED_STRICT_PRIO_EN
                if (SELECTOR_WIDTH'(i) > r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SELECTOR_WIDTH'(i);
                end
`endif
            end
        end
        w_found = w_lo_found;
`ifdef CTRL_ROUTE_SCHED_STRICT_PRIO_EN
        w_winner = w_lo_idx;
`else
        // Sources above the pointer take precedence, otherwise wrap to the lowest.
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
`endif
    end

    // Pick the winner's destination slice and range-check it against D_COUNT.
    always_comb begin
        w_dest = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (w_winner == SELECTOR_WIDTH'(i)) begin
                w_dest = s_desc_tdata[i*DISPATCHER_WIDTH +: DISPATCHER_WIDTH];
            end
        end
        w_dest_ok = ({{(32-DISPATCHER_WIDTH){1'b0}}, w_dest} < 32'(D_COUNT));
    end

    // Next-state and handshake decode; grants only from IDLE with credit available.
    always_comb begin
        w_state_next    = r_state;
        w_accept        = 1'b0;
        w_issue         = 1'b0;
        w_bad           = 1'b0;
        w_sel_vld_next  = r_sel_vld;
        w_disp_vld_next = r_disp_vld;
        case (r_state)
            IDLE: begin
                if (!rst && w_found && (r_count < MAX_CNT)) begin
                    w_accept = 1'b1;
                    if (w_dest_ok) begin
                        w_issue         = 1'b1;
                        w_sel_vld_next  = 1'b1;
                        w_disp_vld_next = 1'b1;
                        w_state_next    = ISSUE;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (r_sel_vld && m_selector_tready) begin
                    w_sel_vld_next = 1'b0;
                end
                if (r_disp_vld && m_dispatcher_tready) begin
                    w_disp_vld_next = 1'b0;
                end
                if (!w_sel_vld_next && !w_disp_vld_next) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // One-hot accept strobe towards the granted source.
    always_comb begin
        s_desc_tready = '0;
        if (w_accept) begin
            s_desc_tready = S_COUNT'(1) << w_winner;
        end
    end

    // Completions only return credit when something is actually outstanding.
    assign w_dec = s_done_tvalid && (r_count != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Token valids and data; data is captured only at grant so it stays stable while valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_vld  <= 1'b0;
            r_disp_vld <= 1'b0;
            r_sel      <= '0;
            r_disp     <= '0;
        end else begin
            r_sel_vld  <= w_sel_vld_next;
            r_disp_vld <= w_disp_vld_next;
            if (w_issue) begin
                r_sel  <= w_winner;
                r_disp <= w_dest;
            end
        end
    end

`ifndef CTRL_ROUTE_SCHED_STRICT_PRIO_EN
    // Pointer follows every accepted descriptor, including dropped bad ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= SELECTOR_WIDTH'(S_COUNT - 1);
        end else if (w_accept) begin
            r_ptr <= w_winner;
        end
    end
`endif

    // In-flight credit counter; a grant and a completion in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_issue && !w_dec) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end else if (!w_issue && w_dec) begin
            r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    // Sticky error flags: bad destination and completion underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 2'b00;
        end else begin
            r_err[0] <= r_err[0] | w_bad;
            r_err[1] <= r_err[1] | (s_done_tvalid && (r_count == '0));
        end
    end

    assign m_selector_tdata    = r_sel;
    assign m_selector_tvalid   = r_sel_vld;
    assign m_dispatcher_tdata  = r_disp;
    assign m_dispatcher_tvalid = r_disp_vld;
    assign inflight_count      = r_count;
    assign err_flags           = r_err;

endmodule

// File: tb/tb_ctrl_route_sched.sv
// tb/tb_ctrl_route_sched.sv - directed self-checking bench for ctrl_route_sched
module tb_ctrl_route_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] desc_tdata;
    logic [1:0] desc_tvalid;
    logic [1:0] desc_tready;
    logic       sel_tdata;
    logic       sel_tvalid;
    logic       sel_tready;
    logic       disp_tdata;
    logic       disp_tvalid;
    logic       disp_tready;
    logic       done;
    logic [2:0] cnt;
    logic [1:0] err;

    logic [3:0] d3_tdata;
    logic [1:0] d3_tvalid;
    logic [1:0] d3_tready;
    logic       d3_sel;
    logic       d3_sel_vld;
    logic [1:0] d3_disp;
    logic       d3_disp_vld;
    logic       d3_done;
    logic [2:0] d3_cnt;
    logic [1:0] d3_err;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_route_sched #(.S_COUNT(2), .D_COUNT(2), .MAX_INFLIGHT(4)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_desc_tdata        (desc_tdata),
        .s_desc_tvalid       (desc_tvalid),
        .s_desc_tready       (desc_tready),
        .m_selector_tdata    (sel_tdata),
        .m_selector_tvalid   (sel_tvalid),
        .m_selector_tready   (sel_tready),
        .m_dispatcher_tdata  (disp_tdata),
        .m_dispatcher_tvalid (disp_tvalid),
        .m_dispatcher_tready (disp_tready),
        .s_done_tvalid       (done),
        .inflight_count      (cnt),
        .err_flags           (err)
    );

    ctrl_route_sched #(.S_COUNT(2), .D_COUNT(3), .MAX_INFLIGHT(4)) u_dut3 (
        .clk                 (clk),
        .rst                 (rst),
        .s_desc_tdata        (d3_tdata),
        .s_desc_tvalid       (d3_tvalid),
        .s_desc_tready       (d3_tready),
        .m_selector_tdata    (d3_sel),
        .m_selector_tvalid   (d3_sel_vld),
        .m_selector_tready   (1'b1),
        .m_dispatcher_tdata  (d3_disp),
        .m_dispatcher_tvalid (d3_disp_vld),
        .m_dispatcher_tready (1'b1),
        .s_done_tvalid       (d3_done),
        .inflight_count      (d3_cnt),
        .err_flags           (d3_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic int exp_src(input int g);
`ifdef CTRL_ROUTE_SCHED_STRICT_PRIO_EN
        return 0;
`else
        return g % 2;
`endif
    endfunction

    initial begin
        rst         = 1'b1;
        desc_tdata  = 2'b00;
        desc_tvalid = 2'b00;
        sel_tready  = 1'b0;
        disp_tready = 1'b0;
        done        = 1'b0;
        d3_tdata    = 4'b0000;
        d3_tvalid   = 2'b00;
        d3_done     = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // reset values
        chk("rst_tready",    32'(desc_tready), 32'd0);
        chk("rst_sel_vld",   32'(sel_tvalid),  32'd0);
        chk("rst_disp_vld",  32'(disp_tvalid), 32'd0);
        chk("rst_sel_data",  32'(sel_tdata),   32'd0);
        chk("rst_disp_data", 32'(disp_tdata),  32'd0);
        chk("rst_count",     32'(cnt),         32'd0);
        chk("rst_err",       32'(err),         32'd0);

        // both sources valid: src0 -> dest1, src1 -> dest0
        desc_tvalid = 2'b11;
        desc_tdata  = 2'b01;
        sel_tready  = 1'b1;
        disp_tready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            int s;
            s = exp_src(g);
            #1;
            chk("grant_tready", 32'(desc_tready), 32'(1 << s));
            cyc();
            chk("issue_sel_vld",  32'(sel_tvalid),  32'd1);
            chk("issue_disp_vld", 32'(disp_tvalid), 32'd1);
            chk("issue_sel",      32'(sel_tdata),   32'(s));
            chk("issue_disp",     32'(disp_tdata),  32'((s == 0) ? 1 : 0));
            chk("issue_count",    32'(cnt),         32'(g + 1));
            chk("issue_no_accept", 32'(desc_tready), 32'd0);
            cyc();
        end
        // credit exhausted
        #1;
        chk("stall_tready", 32'(desc_tready), 32'd0);
        chk("stall_count",  32'(cnt),         32'd4);
        cyc();
        chk("stall_sel_vld", 32'(sel_tvalid), 32'd0);
        chk("stall_tready2", 32'(desc_tready), 32'd0);

        // one completion at full credit: grant only from the next cycle
        done = 1'b1;
        #1;
        chk("done_full_tready", 32'(desc_tready), 32'd0);
        cyc();
        done = 1'b0;
        #1;
        chk("done_count3",   32'(cnt),         32'd3);
        chk("regrant_tready", 32'(desc_tready), 32'd1);
        cyc();
        chk("regrant_sel",   32'(sel_tdata),  32'd0);
        chk("regrant_disp",  32'(disp_tdata), 32'd1);
        chk("regrant_count", 32'(cnt),        32'd4);
        cyc();
        chk("regrant_stall", 32'(desc_tready), 32'd0);

        // drain credits, then one extra completion underflows
        desc_tvalid = 2'b00;
        done = 1'b1;
        repeat (4) cyc();
        chk("drain_count", 32'(cnt), 32'd0);
        chk("drain_err",   32'(err), 32'd0);
        cyc();
        done = 1'b0;
        chk("underflow_count", 32'(cnt), 32'd0);
        chk("underflow_err",   32'(err), 32'd2);

        // selector accepted at t, dispatcher held off until t+3
        sel_tready  = 1'b1;
        disp_tready = 1'b0;
        desc_tvalid = 2'b10;
        #1;
        chk("slow_grant_tready", 32'(desc_tready), 32'd2);
        cyc();
        desc_tvalid = 2'b11;
        #1;
        chk("t0_sel_vld",  32'(sel_tvalid),  32'd1);
        chk("t0_disp_vld", 32'(disp_tvalid), 32'd1);
        chk("t0_sel",      32'(sel_tdata),   32'd1);
        chk("t0_disp",     32'(disp_tdata),  32'd0);
        chk("t0_tready",   32'(desc_tready), 32'd0);
        cyc();
        chk("t1_sel_vld",  32'(sel_tvalid),  32'd0);
        chk("t1_disp_vld", 32'(disp_tvalid), 32'd1);
        chk("t1_tready",   32'(desc_tready), 32'd0);
        cyc();
        chk("t2_disp_vld", 32'(disp_tvalid), 32'd1);
        chk("t2_disp",     32'(disp_tdata),  32'd0);
        chk("t2_tready",   32'(desc_tready), 32'd0);
        cyc();
        disp_tready = 1'b1;
        #1;
        chk("t3_disp_vld", 32'(disp_tvalid), 32'd1);
        chk("t3_disp",     32'(disp_tdata),  32'd0);
        chk("t3_tready",   32'(desc_tready), 32'd0);
        cyc();
        chk("t4_disp_vld", 32'(disp_tvalid), 32'd0);
        chk("t4_tready",   32'(desc_tready), 32'd1);
        chk("t4_count",    32'(cnt),         32'd1);
        desc_tvalid = 2'b00;

        // reset while a token pair is pending
        sel_tready  = 1'b0;
        disp_tready = 1'b0;
        desc_tvalid = 2'b10;
        cyc();
        desc_tvalid = 2'b00;
        chk("pre_rst_sel_vld", 32'(sel_tvalid), 32'd1);
        chk("pre_rst_count",   32'(cnt),        32'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_sel_vld",  32'(sel_tvalid),  32'd0);
        chk("mid_rst_disp_vld", 32'(disp_tvalid), 32'd0);
        chk("mid_rst_sel",      32'(sel_tdata),   32'd0);
        chk("mid_rst_disp",     32'(disp_tdata),  32'd0);
        chk("mid_rst_count",    32'(cnt),         32'd0);
        chk("mid_rst_err",      32'(err),         32'd0);
        desc_tvalid = 2'b11;
        sel_tready  = 1'b1;
        disp_tready = 1'b1;
        #1;
        chk("post_rst_tready", 32'(desc_tready), 32'd1);
        cyc();
        chk("post_rst_sel", 32'(sel_tdata), 32'd0);
        cyc();

        // src0 gone: src1 served; grant and completion in the same cycle
        desc_tvalid = 2'b10;
        done = 1'b1;
        #1;
        chk("src1_tready", 32'(desc_tready), 32'd2);
        cyc();
        done = 1'b0;
        desc_tvalid = 2'b00;
        chk("net_count", 32'(cnt),       32'd1);
        chk("src1_sel",  32'(sel_tdata), 32'd1);
        cyc();

        // D_COUNT=3: out-of-range destination is consumed and flagged
        d3_tvalid = 2'b10;
        d3_tdata  = 4'b1100;
        #1;
        chk("bad_tready", 32'(d3_tready), 32'd2);
        cyc();
        d3_tvalid = 2'b00;
        #1;
        chk("bad_sel_vld",  32'(d3_sel_vld),  32'd0);
        chk("bad_disp_vld", 32'(d3_disp_vld), 32'd0);
        chk("bad_err",      32'(d3_err),      32'd1);
        chk("bad_count",    32'(d3_cnt),      32'd0);
        chk("bad_tready_off", 32'(d3_tready), 32'd0);
        d3_tvalid = 2'b01;
        d3_tdata  = 4'b0010;
        #1;
        chk("d3_ok_tready", 32'(d3_tready), 32'd1);
        cyc();
        d3_tvalid = 2'b00;
        chk("d3_ok_sel_vld", 32'(d3_sel_vld), 32'd1);
        chk("d3_ok_sel",     32'(d3_sel),     32'd0);
        chk("d3_ok_disp",    32'(d3_disp),    32'd2);
        chk("d3_ok_count",   32'(d3_cnt),     32'd1);
        chk("d3_ok_err",     32'(d3_err),     32'd1);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
